// File: rtl/soc_cpu_oci_dct_capture.sv
// Trace-entry packer: gathers ENTRIES trace entries per word, hands words off over valid/ready,
// flushes a partial word at end of test and then raises a sticky end flag.
module soc_cpu_oci_dct_capture #(
    parameter int ENTRY_W = 15,
    parameter int ENTRIES = 2,
    parameter int CNT_W   = 4,
    parameter int OVF_W   = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       trace_valid,
    input  logic [ENTRY_W-1:0]         trace_data,
    input  logic                       test_ending,
    output logic                       dct_valid,
    input  logic                       dct_ready,
    output logic [ENTRY_W*ENTRIES-1:0] dct_buffer,
    output logic [CNT_W-1:0]           dct_count,
    output logic [OVF_W-1:0]           overflow_count,
    output logic                       test_has_ended
);

    localparam int BUF_W = ENTRY_W * ENTRIES;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(ENTRIES);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ENTRIES - 1);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_ENDED
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   fc_q, fc_d;
    logic [BUF_W-1:0]   fill_q, fill_d;
    logic               valid_q, valid_d;
    logic [BUF_W-1:0]   buf_q, buf_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [OVF_W-1:0]   ovf_q, ovf_d;
    logic               ended_q, ended_d;

    logic               ofree;
    logic               fill_full;
    logic [ENTRIES-1:0] slot_sel;
    logic [BUF_W-1:0]   fill_wr;

    assign ofree     = !valid_q || dct_ready;
    assign fill_full = (fc_q == FULL_CNT);

    // Fill contents with the incoming entry written into slot fc.
    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_slot
            assign slot_sel[gi] = (fc_q == CNT_W'(gi));
            assign fill_wr[gi*ENTRY_W +: ENTRY_W] =
                slot_sel[gi] ? trace_data : fill_q[gi*ENTRY_W +: ENTRY_W];
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        fc_d    = fc_q;
        fill_d  = fill_q;
        valid_d = valid_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        ended_d = ended_q;

        // A consumed word leaves the output zeroed unless a new load below overrides it.
        if (valid_q && dct_ready) begin
            valid_d = 1'b0;
            buf_d   = '0;
            cnt_d   = '0;
        end

        case (state_q)
            ST_RUN: begin
                if (fill_full) begin
                    if (ofree) begin
                        valid_d = 1'b1;
                        buf_d   = fill_q;
                        cnt_d   = FULL_CNT;
                        fill_d  = '0;
                        fc_d    = '0;
                        if (trace_valid) begin
                            fill_d[ENTRY_W-1:0] = trace_data;
                            fc_d                = CNT_W'(1);
                        end
                    end else if (trace_valid && (ovf_q != '1)) begin
                        ovf_d = ovf_q + OVF_W'(1);
                    end
                end else if (trace_valid) begin
                    if ((fc_q == LAST_CNT) && ofree) begin
                        valid_d = 1'b1;
                        buf_d   = fill_wr;
                        cnt_d   = FULL_CNT;
                        fill_d  = '0;
                        fc_d    = '0;
                    end else begin
                        fill_d = fill_wr;
                        fc_d   = fc_q + CNT_W'(1);
                    end
                end
                if (test_ending) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if ((fc_q != '0) && ofree) begin
                    valid_d = 1'b1;
                    buf_d   = fill_q;
                    cnt_d   = fc_q;
                    fill_d  = '0;
                    fc_d    = '0;
                end else if ((fc_q == '0) && ofree) begin
                    state_d = ST_ENDED;
                    ended_d = 1'b1;
                end
            end
            ST_ENDED: begin
                ended_d = 1'b1;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
            fc_q    <= '0;
            fill_q  <= '0;
            valid_q <= 1'b0;
            buf_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= '0;
            ended_q <= 1'b0;
        end else begin
            state_q <= state_d;
            fc_q    <= fc_d;
            fill_q  <= fill_d;
            valid_q <= valid_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            ended_q <= ended_d;
        end
    end

    assign dct_valid      = valid_q;
    assign dct_buffer     = buf_q;
    assign dct_count      = cnt_q;
    assign overflow_count = ovf_q;
    assign test_has_ended = ended_q;

endmodule

// File: tb/tb_soc_cpu_oci_dct_capture.sv
// Directed bench for the DCT packer: main instance with default widths, second instance with a
// 2-bit overflow counter for saturation.
module tb_soc_cpu_oci_dct_capture;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        trace_valid = 1'b0;
    logic [14:0] trace_data = '0;
    logic        test_ending = 1'b0;
    logic        dct_ready = 1'b0;
    logic        dct_valid;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic [7:0]  overflow_count;
    logic        test_has_ended;

    logic        tv2 = 1'b0;
    logic [14:0] td2 = '0;
    logic        dct_valid2;
    logic [29:0] dct_buffer2;
    logic [3:0]  dct_count2;
    logic [1:0]  overflow_count2;
    logic        test_has_ended2;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    soc_cpu_oci_dct_capture #(.ENTRY_W(15), .ENTRIES(2), .CNT_W(4), .OVF_W(8)) dut (
        .clk(clk), .reset(reset), .trace_valid(trace_valid), .trace_data(trace_data),
        .test_ending(test_ending), .dct_valid(dct_valid), .dct_ready(dct_ready),
        .dct_buffer(dct_buffer), .dct_count(dct_count), .overflow_count(overflow_count),
        .test_has_ended(test_has_ended)
    );

    soc_cpu_oci_dct_capture #(.ENTRY_W(15), .ENTRIES(2), .CNT_W(4), .OVF_W(2)) dut2 (
        .clk(clk), .reset(reset), .trace_valid(tv2), .trace_data(td2),
        .test_ending(1'b0), .dct_valid(dct_valid2), .dct_ready(1'b0),
        .dct_buffer(dct_buffer2), .dct_count(dct_count2), .overflow_count(overflow_count2),
        .test_has_ended(test_has_ended2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
        $display("check %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, 32'(dct_valid), 32'h0);
        check({tag, "_buffer"}, 32'(dct_buffer), 32'h0);
        check({tag, "_count"}, 32'(dct_count), 32'h0);
    endtask

    initial begin
        // Reset held for three cycles
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check_idle("rst");
        check("rst_ovf", 32'(overflow_count), 32'h0);
        check("rst_ended", 32'(test_has_ended), 32'h0);

        // Two-entry pack
        dct_ready = 1'b1;
        trace_valid = 1'b1; trace_data = 15'h0001; tick();
        check("pack_not_yet", 32'(dct_valid), 32'h0);
        trace_data = 15'h7FFF; tick();
        trace_valid = 1'b0;
        check("pack_valid", 32'(dct_valid), 32'h1);
        check("pack_buffer", 32'(dct_buffer), 32'h3FFF8001);
        check("pack_count", 32'(dct_count), 32'h2);
        tick();
        check_idle("pack_done");

        // Back-pressure and drop: entries 1..6 with the sink stalled
        dct_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            trace_valid = 1'b1; trace_data = 15'(i); tick();
            if (i == 4) check("bp_hold_at4", 32'(dct_buffer), 32'h00010001);
        end
        trace_valid = 1'b0;
        check("bp_valid", 32'(dct_valid), 32'h1);
        check("bp_buffer", 32'(dct_buffer), 32'h00010001);
        check("bp_count", 32'(dct_count), 32'h2);
        check("bp_ovf", 32'(overflow_count), 32'h2);
        dct_ready = 1'b1; tick();
        check("bp_next_valid", 32'(dct_valid), 32'h1);
        check("bp_next_buffer", 32'(dct_buffer), 32'h00020003);
        check("bp_next_count", 32'(dct_count), 32'h2);
        check("bp_ovf_stays", 32'(overflow_count), 32'h2);
        tick();
        check_idle("bp_drained");

        // Partial flush
        dct_ready = 1'b0;
        trace_valid = 1'b1; trace_data = 15'h1234; tick();
        trace_valid = 1'b0; test_ending = 1'b1; tick();
        test_ending = 1'b0; tick();
        check("flush_valid", 32'(dct_valid), 32'h1);
        check("flush_buffer", 32'(dct_buffer), 32'h00001234);
        check("flush_count", 32'(dct_count), 32'h1);
        check("flush_not_ended", 32'(test_has_ended), 32'h0);
        tick();
        check("flush_held", 32'(dct_buffer), 32'h00001234);
        dct_ready = 1'b1; tick();
        tick();
        check("flush_ended", 32'(test_has_ended), 32'h1);
        check_idle("flush_out");
        trace_valid = 1'b1; trace_data = 15'h0005; tick();
        trace_data = 15'h0006; tick();
        test_ending = 1'b1; tick();
        trace_valid = 1'b0; test_ending = 1'b0; tick();
        check_idle("ended_ignore");
        check("ended_sticky", 32'(test_has_ended), 32'h1);
        check("ended_ovf", 32'(overflow_count), 32'h2);

        // Reset while a flushed word is held in DRAIN
        reset = 1'b1; tick();
        reset = 1'b0; tick();
        dct_ready = 1'b0;
        trace_valid = 1'b1; trace_data = 15'h0009; tick();
        trace_valid = 1'b0; test_ending = 1'b1; tick();
        test_ending = 1'b0; tick();
        check("mid_valid", 32'(dct_valid), 32'h1);
        check("mid_buffer", 32'(dct_buffer), 32'h00000009);
        reset = 1'b1; #1;
        check_idle("mid_rst_async");
        tick();
        reset = 1'b0;
        check("mid_rst_ovf", 32'(overflow_count), 32'h0);
        check("mid_rst_ended", 32'(test_has_ended), 32'h0);
        dct_ready = 1'b1;
        trace_valid = 1'b1; trace_data = 15'h0AAA; tick();
        trace_data = 15'h0555; tick();
        trace_valid = 1'b0;
        check("repack_buffer", 32'(dct_buffer), 32'h02AA8AAA);
        check("repack_count", 32'(dct_count), 32'h2);
        tick();
        check_idle("repack_done");

        // Ending with nothing buffered: flag one edge after the DRAIN entry
        test_ending = 1'b1; tick();
        test_ending = 1'b0;
        check("empty_end_t", 32'(test_has_ended), 32'h0);
        tick();
        check("empty_end_t1", 32'(test_has_ended), 32'h1);

        // Saturation of the 2-bit counter: 4 entries stored, then 5 dropped
        reset = 1'b1; tick();
        reset = 1'b0; tick();
        for (int i = 1; i <= 9; i++) begin
            tv2 = 1'b1; td2 = 15'(i); tick();
            if (i == 6) check("sat_two_drops", 32'(overflow_count2), 32'h2);
        end
        tv2 = 1'b0;
        check("sat_ovf", 32'(overflow_count2), 32'h3);
        check("sat_buffer", 32'(dct_buffer2), 32'h00010001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/soc_cpu_oci_dct_capture.md
# soc_cpu_oci_dct_capture

Parametrised debug-capture-trace (DCT) packer for the Nios II OCI debug path. It accepts a stream of fixed-width trace entries, packs `ENTRIES` of them into one `dct_buffer` word with a `dct_count`, and hands each word off over a valid/ready handshake. When a test ends it flushes any partial buffer and then raises a sticky `test_has_ended` flag. Words that arrive while all storage is occupied are dropped and counted. It sits between the CPU trace source and the OCI test bench / trace sink.

## Interface
- `ENTRY_W`, 15, width of one trace entry.
- `ENTRIES`, 2, number of entries per buffer word; must be at least 1.
- `CNT_W`, 4, width of `dct_count`; must be at least clog2(`ENTRIES`+1).
- `OVF_W`, 8, width of the dropped-entry counter.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `reset`  in  1  asynchronous, active-high reset.
- `trace_valid`  in  1  a trace entry is presented this cycle.
- `trace_data`  in  `ENTRY_W`  trace entry payload.
- `test_ending`  in  1  single-cycle request to flush and end.
- `dct_valid`  out  1  `dct_buffer`/`dct_count` hold a word.
- `dct_ready`  in  1  sink accepts the word this cycle.
- `dct_buffer`  out  `ENTRY_W*ENTRIES`  packed entries.
- `dct_count`  out  `CNT_W`  valid entries in `dct_buffer`.
- `overflow_count`  out  `OVF_W`  dropped entries, saturating.
- `test_has_ended`  out  1  sticky end-of-test flag.

## Operation
- **Storage.** There are two registers.
  - Fill register: `ENTRIES` slots plus a fill count `fc`.
  - Output register: drives the `dct_*` outputs.
- **Packing.**
  - Entry k (0 = oldest) occupies bits [k*ENTRY_W +: ENTRY_W].
  - Slots at or above `dct_count` are 0.
- **Output free (`ofree`).** `ofree` = !`dct_valid` || `dct_ready`.
- **RUN state (the state after reset).**
  - Accept: `trace_valid` && `fc` < `ENTRIES` writes the entry into slot `fc`.
  - Direct load: if the entry completes the fill (`fc` = `ENTRIES`-1) and `ofree` is true:
    - the output register loads the packed data with `dct_count`=`ENTRIES`;
    - `fc` goes to 0.
  - Deferred load: if the fill is already full and `ofree` is true, the full fill moves to the output register and `fc` goes to 0.
    - A `trace_valid` in that same cycle is written to slot 0, so `fc` becomes 1.
  - Drop: `trace_valid` while the fill is full and not transferring this cycle discards the entry.
    - `overflow_count` increments and saturates at all-ones.
  - `test_ending` moves the state to DRAIN.
    - An entry accepted in the same cycle is included in the flush.
- **DRAIN state.**
  - `trace_valid` is ignored and not counted.
  - If `fc` > 0 and `ofree`, the output loads the partial fill with `dct_count`=`fc`.
  - When `fc`=0 and the output register is empty (`dct_valid`=0, or being consumed this cycle), the state moves to ENDED.
- **ENDED state.**
  - `test_has_ended`=1.
  - All inputs except `reset` are ignored.
  - The state is terminal until reset.
- **Output hold rule.** While `dct_valid` && !`dct_ready`, `dct_buffer` and `dct_count` hold stable.
- **Output clear rule.** When a handshake completes and no new word is loaded, `dct_valid`, `dct_buffer` and `dct_count` go to 0.
- **Reset.** Asserting `reset` at any time clears everything:
  - all outputs go to 0;
  - `fc`=0;
  - state returns to RUN.
  - Any in-flight word is lost.

## Timing
- **Reset values.** `dct_valid`=0, `dct_buffer`=0, `dct_count`=0, `overflow_count`=0, `test_has_ended`=0.
- **Load latency.** The entry completing a word is sampled at edge t. With `ofree` true, `dct_valid`=1 after edge t.
- **Throughput.** One full word per `ENTRIES` cycles is sustained when `dct_ready`=1.
- **Back-to-back words.** A word is consumed at edge t while the fill is full. The next word is presented after edge t, with no bubble.
- **Ending latency.** `test_ending` is sampled at edge t:
  - with `fc`=0 and the output empty, `test_has_ended`=1 after edge t+1;
  - otherwise it rises one edge after the last word's handshake.
- **Redundant `test_ending`.** A `test_ending` seen in DRAIN or ENDED has no effect.

## Test plan
- **Reset values.** Hold `reset` for 3 cycles, then release. Required: all outputs are 0.
- **Two-entry pack.** Present 0x0001 then 0x7FFF with `dct_ready`=1. Required: one cycle after the second entry, `dct_valid`=1, `dct_buffer`=0x3FFF8001, `dct_count`=2, held for one cycle.
- **Back-pressure and drop.**
  - Stimulus: `dct_ready`=0; stream 6 entries 1..6.
  - Required:
    - output holds {2,1} with `dct_count`=2;
    - fill holds {3,4};
    - `overflow_count`=2.
  - Then raise `dct_ready`. Required: {4,3} is presented next with no bubble; `overflow_count` stays at 2.
- **Partial flush.** Present one entry 0x1234, then pulse `test_ending`. Required:
  - `dct_buffer`=0x00001234, `dct_count`=1;
  - after the handshake, `test_has_ended`=1, sticky;
  - a later `trace_valid` produces no output.
- **Overflow saturation.** Use `OVF_W`=2 and `dct_ready`=0. Drop 5 entries. Required: `overflow_count`=3.
- **Reset mid-operation.** Assert `reset` while `dct_valid`=1 in DRAIN. Required:
  - all outputs are 0 and the state is RUN;
  - a new 2-entry pack works normally.
